// File: rtl/clk_divider_prog.sv
// clk_divider_prog: runtime-programmable integer clock divider.
// Divides clk_in by N in 2..2^WIDTH-1 and produces:
//   clk_flag : one-cycle enable pulse, high while cnt_out == N-1
//   clk_out  : divided square wave, high while cnt_out < floor(N/2)
// A new ratio is captured by div_load into a pending register and becomes
// active on the next N-1 -> 0 wrap. A running period is never truncated.
// Optional feature macro: CLK_DIV_ODD50_EN
//   When defined, a negedge flop re-times clk_out so that odd ratios give a
//   50% duty cycle. When undefined, only posedge logic is used.
module clk_divider_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 6
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic             div_load,
  output logic             div_busy,
  output logic             clk_flag,
  output logic             clk_out,
  output logic [WIDTH-1:0] cnt_out
);

  localparam logic [WIDTH-1:0] RATIO_RST = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO       = WIDTH'(2);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] ratio_q;
  logic [WIDTH-1:0] pend_q;
  logic             busy_q;
  logic             flag_q;
  logic             out_q;

  logic [WIDTH-1:0] ld_val;
  logic             wrap;
  logic [WIDTH-1:0] ratio_nxt;
  logic [WIDTH-1:0] cnt_nxt;

  // Next-state decode: the new ratio takes effect together with the wrap so
  // the flag and clk_out of the first cycle of the new period use it.
  always_comb begin
    ld_val    = (div_ratio < TWO) ? TWO : div_ratio;
    // >= rather than == keeps the counter bounded even if it ever exceeds N-1
    wrap      = (cnt_q >= (ratio_q - ONE));
    ratio_nxt = (wrap && busy_q) ? pend_q : ratio_q;
    cnt_nxt   = wrap ? '0 : (cnt_q + ONE);
  end

  // Counter, active/pending ratio and registered outputs (decoded from next count).
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      ratio_q <= RATIO_RST;
      pend_q  <= '0;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
      out_q   <= 1'b0;
    end else if (en) begin
      cnt_q   <= cnt_nxt;
      ratio_q <= ratio_nxt;
      flag_q  <= (cnt_nxt == (ratio_nxt - ONE));
      out_q   <= (cnt_nxt < (ratio_nxt >> 1));
      // A load on the wrap edge still lands in pending after the old pending
      // value was promoted, so it waits for the following wrap.
      if (div_load) begin
        pend_q <= ld_val;
        busy_q <= 1'b1;
      end else if (wrap && busy_q) begin
        busy_q <= 1'b0;
      end
    end else begin
      // Frozen: everything holds except the flag, which must not repeat.
      flag_q <= 1'b0;
    end
  end

`ifdef CLK_DIV_ODD50_EN
  logic neg_q;

  // Half-cycle delayed copy of the posedge term; OR-ing it in extends the
  // high phase by half a clk_in period for odd ratios.
  always_ff @(negedge clk_in or negedge reset_n) begin
    if (!reset_n) neg_q <= 1'b0;
    else          neg_q <= out_q;
  end

  assign clk_out = out_q | (ratio_q[0] & neg_q);
`else
  assign clk_out = out_q;
`endif

  assign clk_flag = flag_q;
  assign div_busy = busy_q;
  assign cnt_out  = cnt_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Scoreboard bench for clk_divider_prog: the driver pushes the expected
// post-edge state for every clk_in edge; a monitor pops and compares it just
// after the posedge (clk_out) and just after the negedge (all outputs).
module tb_clk_divider_prog;
  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         reset_n;
  logic         en;
  logic [W-1:0] div_ratio;
  logic         div_load;
  logic         div_busy;
  logic         clk_flag;
  logic         clk_out;
  logic [W-1:0] cnt_out;

  clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(6)) dut (
    .clk_in(clk_in), .reset_n(reset_n), .en(en), .div_ratio(div_ratio),
    .div_load(div_load), .div_busy(div_busy), .clk_flag(clk_flag),
    .clk_out(clk_out), .cnt_out(cnt_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int cnt;
    bit flag;
    bit out_pos;
    bit out_neg;
    bit busy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // spec-level reference state
  int m_cnt, m_n, m_pn, m_busy, m_flag, m_out, m_prev;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_n = 6; m_pn = 0; m_busy = 0; m_flag = 0; m_out = 0; m_prev = 0;
  endtask

  // One clk_in edge: advance the reference with the inputs that were set
  // before this edge, then queue the expected outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk_in);
    if (!reset_n) begin
      model_reset();
    end else if (en) begin
      if (m_cnt >= m_n - 1) begin
        m_cnt = 0;
        if (m_busy != 0) begin m_n = m_pn; m_busy = 0; end
      end else begin
        m_cnt = m_cnt + 1;
      end
      if (div_load) begin
        m_pn = (div_ratio < 2) ? 2 : int'(div_ratio);
        m_busy = 1;
      end
      m_prev = m_out;
      m_out  = (m_cnt < m_n / 2) ? 1 : 0;
      m_flag = (m_cnt == m_n - 1) ? 1 : 0;
    end else begin
      m_prev = m_out;
      m_flag = 0;
    end
    e.cnt = m_cnt; e.flag = m_flag[0]; e.busy = m_busy[0]; e.out_neg = m_out[0];
`ifdef CLK_DIV_ODD50_EN
    e.out_pos = m_out[0] | ((m_n % 2 == 1) ? m_prev[0] : 1'b0);
`else
    e.out_pos = m_out[0];
`endif
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick until the cycle in which cnt == target, bounded.
  task automatic wait_cnt(input int target);
    int k = 0;
    while (m_cnt != target && k < 600) begin tick(); k++; end
    if (m_cnt != target) chk("wait_cnt_timeout", m_cnt, target);
  endtask

  task automatic load(input int r);
    #1 div_ratio = W'(r); div_load = 1'b1;
    tick();
    #1 div_load = 1'b0;
  endtask

  // Monitor: compares each queued expectation against the DUT.
  initial begin
    exp_t e;
    logic pos_s;
    forever begin
      @(posedge clk_in);
      #2;
      if (q.size() > 0) begin
        pos_s = clk_out;
        @(negedge clk_in);
        #1;
        e = q.pop_front();
        chk("cnt_out",        int'(cnt_out),  e.cnt);
        chk("clk_flag",       int'(clk_flag), int'(e.flag));
        chk("div_busy",       int'(div_busy), int'(e.busy));
        chk("clk_out_negedge", int'(clk_out), int'(e.out_neg));
        chk("clk_out_posedge", int'(pos_s),   int'(e.out_pos));
      end
    end
  end

  initial begin
    int k;
    reset_n = 1'b0; en = 1'b1; div_ratio = '0; div_load = 1'b0;
    model_reset();
    run(2);                       // reset state: all zero
    #1 reset_n = 1'b1;

    // 1: default /6, clk_out 111000 after the first period
    run(18);

    // 2: load 5 mid-period; applies at next wrap
    wait_cnt(1);
    load(5);
    run(16);

    // back to /6 for the loads-during-period test
    load(6);
    run(12);

    // 4: load 3 at cnt=2, then 4 at cnt=4; last one wins
    wait_cnt(0);
    wait_cnt(2);
    load(3);
    wait_cnt(4);
    load(4);
    run(12);

    // load in the wrap cycle applies only at the following wrap
    wait_cnt(3);
    load(7);
    run(16);

    // 5: 0 and 1 both clamp to /2
    load(0);
    run(10);
    load(1);
    run(6);

    // 6: freeze at cnt=3 for 4 cycles under /6
    load(6);
    run(8);
    wait_cnt(3);
    #1 en = 1'b0;
    run(4);
    #1 en = 1'b1;
    run(8);

    // reset mid-period with a pending ratio: pending is lost, back to /6
    load(9);
    wait_cnt(2);
    @(negedge clk_in);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_cnt",  int'(cnt_out),  0);
    chk("async_rst_flag", int'(clk_flag), 0);
    chk("async_rst_out",  int'(clk_out),  0);
    chk("async_rst_busy", int'(div_busy), 0);
    run(1);
    #1 reset_n = 1'b1;
    run(14);

    k = 0;
    while (q.size() > 0 && k < 20) begin @(posedge clk_in); k++; end
    if (q.size() > 0) chk("scoreboard_drain", q.size(), 0);
    @(posedge clk_in);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
